pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the pipelined RISC-V core, the general replacement for the hand-written inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary payload plus a separate control field between two stages using a valid/ready handshake. A two-entry skid buffer keeps full throughput while giving the upstream stage a registered `in_ready`. It supports hazard stalls through `out_ready` and branch-mispredict flushes that insert bubbles with zeroed control.

---
 rtl/pipe_pkg.sv | 52 +++++
 rtl/pipe_slot.sv | 36 +++
 rtl/pipe_stage_reg.sv | 157 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the core's inter-stage pipeline registers:
// occupancy state encoding, default per-stage widths and control layouts.
package pipe_pkg;

    // Occupancy state of a pipeline stage register
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // ID/EX control: what the execute, memory and writeback stages need
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_op;
    } id_ex_ctrl_t;

    // EX/MEM control: memory access plus what writeback still needs
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] mem_funct3;
        logic       branch_taken;
    } ex_mem_ctrl_t;

    // MEM/WB control: writeback selection only
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [1:0] wb_sel;
    } mem_wb_ctrl_t;

    // IF/ID carries {pc, instr}; the only control bit is the predictor's guess
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned IF_ID_CTRL_W  = 1;
    // {pc, rs1_val, rs2_val, imm, rs1, rs2, rd}
    localparam int unsigned ID_EX_DATA_W  = 143;
    localparam int unsigned ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    // {alu_result, rs2_val, rd}
    localparam int unsigned EX_MEM_DATA_W = 69;
    localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    // {mem_data, alu_result, rd}
    localparam int unsigned MEM_WB_DATA_W = 69;
    localparam int unsigned MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

endpackage

// File: rtl/pipe_slot.sv
// One pipeline-stage storage slot holding {valid, data, ctrl}.
// Ports: clk, rst_n (async active-low), load (capture load_data/load_ctrl,
// set valid), clear (drop entry; wins over load), valid/data/ctrl outputs.
// ctrl is zeroed whenever the slot is invalid; data may stay stale.
module pipe_slot #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Valid and ctrl always move together so an empty slot reads as a NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a two-entry skid buffer.
// Ports: clk, reset (async active-low), flush (sync kill of held entries),
// in_valid/in_ready/in_data/in_ctrl upstream handshake, out_valid/out_ready/
// out_data/out_ctrl downstream handshake, occupancy (entries held, 0..2).
// in_ready and out_valid decode the state register only, so neither side
// sees a combinational path from the other.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);
    import pipe_pkg::*;

    pipe_state_e state;
    pipe_state_e state_next;

    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_load_data;
    logic [CTRL_W-1:0] main_load_ctrl;
    logic              in_fire;
    logic              out_fire;

    // Handshake decode from the state register
    assign in_ready  = (state != TWO);
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and slot steering; flush overrides every transition
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_load  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load  = 1'b1;
                        state_next = TWO;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // Skid entry is older than anything upstream; promote it
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_load_data = main_from_skid ? skid_data : in_data;
    assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk       (clk),
        .rst_n     (reset),
        .load      (main_load),
        .clear     (main_clear),
        .load_data (main_load_data),
        .load_ctrl (main_load_ctrl),
        .valid     (main_valid),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
    );

    // skid_valid mirrors state == TWO; kept for debug visibility only
    logic unused_ok;
    assign unused_ok = skid_valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random
// run, all compared against a two-entry FIFO reference model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  ctrl;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;

    entry_t model_q[$];
    int     n_checks;
    int     n_fail;
    int     n_accepted;

    pipe_stage_reg #(
        .DATA_W (64),
        .CTRL_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all DUT outputs against the model's current contents
    task automatic compare_all(input string tag);
        logic v;
        v = (model_q.size() > 0);
        check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        check_eq({tag, ".out_ctrl"}, 64'(out_ctrl), v ? 64'(model_q[0].ctrl) : 64'd0);
        if (v) check_eq({tag, ".out_data"}, out_data, model_q[0].data);
        check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(model_q.size() < 2));
        check_eq({tag, ".occupancy"}, 64'(occupancy), 64'(model_q.size()));
    endtask

    // One clock: drive inputs (we sit at a negedge), advance the model,
    // clock the DUT, then compare at the following negedge.
    task automatic step(input logic iv, input logic [63:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl, input string tag,
                        output logic accepted);
        int sz;
        entry_t e;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        sz        = model_q.size();
        accepted  = 1'b0;
        if (fl) begin
            model_q.delete();
        end else begin
            if (sz > 0 && ordy) void'(model_q.pop_front());
            if (sz < 2 && iv) begin
                e.data = d;
                e.ctrl = c;
                model_q.push_back(e);
                accepted = 1'b1;
                n_accepted++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    // Present one entry until accepted, with a bounded wait
    task automatic send_hold(input logic [63:0] d, input logic [7:0] c, input logic ordy,
                             input string tag);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, d, c, ordy, 1'b0, tag, acc);
            tries++;
        end
        check_eq({tag, ".accept_timeout"}, 64'(acc), 64'd1);
    endtask

    initial begin
        logic acc;
        n_checks   = 0;
        n_fail     = 0;
        n_accepted = 0;
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_ctrl    = '0;
        out_ready  = 1'b0;

        // Reset values
        #1;
        check_eq("reset.out_valid", 64'(out_valid), 64'd0);
        check_eq("reset.out_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("reset.out_data", out_data, 64'd0);
        check_eq("reset.in_ready", 64'(in_ready), 64'd1);
        check_eq("reset.occupancy", 64'(occupancy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        compare_all("post_reset");

        // Streaming at full throughput: one-cycle latency, occupancy 1
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 64'(i), 8'(i), 1'b1, 1'b0, "stream", acc);
            check_eq("stream.accepted", 64'(acc), 64'd1);
            check_eq("stream.latency", out_data, 64'(i));
            check_eq("stream.occ", 64'(occupancy), 64'd1);
        end
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0, "drain", acc);

        // Stall fills the skid, 0xC waits, then all drain in order
        step(1'b1, 64'hA, 8'h1A, 1'b0, 1'b0, "stall_a", acc);
        step(1'b1, 64'hB, 8'h1B, 1'b0, 1'b0, "stall_b", acc);
        check_eq("stall.occ2", 64'(occupancy), 64'd2);
        check_eq("stall.in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 64'hC, 8'h1C, 1'b0, 1'b0, "stall_c", acc);
        check_eq("stall.c_rejected", 64'(acc), 64'd0);
        check_eq("stall.head_a", out_data, 64'hA);
        send_hold(64'hC, 8'h1C, 1'b1, "release_c");
        for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0, "drain_abc", acc);
        check_eq("drain_abc.empty", 64'(occupancy), 64'd0);

        // Flush with two held entries and a simultaneous input
        step(1'b1, 64'h11, 8'hFF, 1'b0, 1'b0, "pre_flush1", acc);
        step(1'b1, 64'h22, 8'hFF, 1'b0, 1'b0, "pre_flush2", acc);
        step(1'b1, 64'hD, 8'hFF, 1'b0, 1'b1, "flush", acc);
        check_eq("flush.out_valid", 64'(out_valid), 64'd0);
        check_eq("flush.out_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("flush.occ", 64'(occupancy), 64'd0);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0, "post_flush", acc);
        check_eq("post_flush.no_d", 64'(out_valid), 64'd0);

        // Flush together with out_fire leaves the stage empty
        step(1'b1, 64'h33, 8'h5, 1'b1, 1'b0, "fl_fire_load", acc);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b1, "fl_fire", acc);

        // Async reset while holding two entries
        step(1'b1, 64'h44, 8'hAA, 1'b0, 1'b0, "pre_rst1", acc);
        step(1'b1, 64'h55, 8'hBB, 1'b0, 1'b0, "pre_rst2", acc);
        check_eq("pre_rst.occ2", 64'(occupancy), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst.out_valid", 64'(out_valid), 64'd0);
        check_eq("async_rst.out_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("async_rst.out_data", out_data, 64'd0);
        check_eq("async_rst.occ", 64'(occupancy), 64'd0);
        check_eq("async_rst.in_ready", 64'(in_ready), 64'd1);
        model_q.delete();
        @(negedge clk);
        reset = 1'b1;
        compare_all("post_async_rst");

        // Random traffic with occasional flushes
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0), "rand", acc);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0, "final_drain", acc);
        check_eq("final.empty", 64'(occupancy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
